mem_access_controller: RTL and testbench

- Sequencer between the CPU datapath's MAR/MDR and the 512x32 synchronous single-port RAM.
- Accepts one read or write request at a time and drives the RAM's address, data and write-enable inputs.
- Absorbs the RAM's registered-address read latency.
- Returns read data in a holding register with a one-cycle done pulse, so the control unit can stall on busy and load the MDR on done.

---
 rtl/mem_access_controller.sv | 123 ++++++++++++
 tb/tb_mem_access_controller.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_controller.sv
// Sequences one read or write between the CPU MAR/MDR and a 512x32 synchronous RAM.
// It absorbs the RAM's registered-address read latency and returns read data with a one-cycle done pulse.
//
// state   | meaning
// IDLE    | waiting for a request; busy low
// RD_ADDR | RAM latches the read address at this edge
// RD_CAP  | RAM read data valid; captured into mem_data_out
// WR      | write strobe high; RAM writes at this edge
// DONE    | one-cycle completion pulse
module mem_access_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 9,
    parameter int MAR_WIDTH  = 32
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  req_read,
    input  logic                  req_write,
    input  logic [MAR_WIDTH-1:0]  mar_in,
    input  logic [DATA_WIDTH-1:0] mdr_in,
    input  logic [DATA_WIDTH-1:0] ram_data_out,
    output logic [ADDR_WIDTH-1:0] ram_address,
    output logic [DATA_WIDTH-1:0] ram_data_in,
    output logic                  ram_write_enable,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    output logic                  busy,
    output logic                  done,
    output logic                  addr_error
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_ADDR = 3'd1,
        RD_CAP  = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] ram_address_q;
    logic [DATA_WIDTH-1:0] ram_data_in_q;
    logic                  ram_write_enable_q;
    logic [DATA_WIDTH-1:0] mem_data_out_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  addr_error_q;
    logic                  out_of_range;

    // Any set bit above the RAM address range makes the request invalid.
    generate
        if (MAR_WIDTH > ADDR_WIDTH) begin : g_range_check
            assign out_of_range = (mar_in[MAR_WIDTH-1:ADDR_WIDTH] != '0);
        end else begin : g_no_range_check
            assign out_of_range = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q            <= IDLE;
            ram_address_q      <= '0;
            ram_data_in_q      <= '0;
            ram_write_enable_q <= 1'b0;
            mem_data_out_q     <= '0;
            busy_q             <= 1'b0;
            done_q             <= 1'b0;
            addr_error_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_read || req_write) begin
                        addr_error_q <= out_of_range;
                        busy_q       <= 1'b1;
                        if (out_of_range) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else if (req_read) begin
                            ram_address_q <= mar_in[ADDR_WIDTH-1:0];
                            state_q       <= RD_ADDR;
                        end else begin
                            ram_address_q      <= mar_in[ADDR_WIDTH-1:0];
                            ram_data_in_q      <= mdr_in;
                            ram_write_enable_q <= 1'b1;
                            state_q            <= WR;
                        end
                    end
                end
                RD_ADDR: begin
                    state_q <= RD_CAP;
                end
                RD_CAP: begin
                    mem_data_out_q <= ram_data_out;
                    state_q        <= DONE;
                    done_q         <= 1'b1;
                end
                WR: begin
                    ram_write_enable_q <= 1'b0;
                    state_q            <= DONE;
                    done_q             <= 1'b1;
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ram_write_enable_q <= 1'b0;
                    busy_q             <= 1'b0;
                    state_q            <= IDLE;
                end
            endcase
        end
    end

    assign ram_address      = ram_address_q;
    assign ram_data_in      = ram_data_in_q;
    assign ram_write_enable = ram_write_enable_q;
    assign mem_data_out     = mem_data_out_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign addr_error       = addr_error_q;

endmodule

// File: tb/tb_mem_access_controller.sv
// Bench for mem_access_controller: a behavioural 512x32 registered-address RAM plus a
// scoreboard of expected read data / addr_error, popped on every done pulse.
module tb_mem_access_controller;

    logic        clk;
    logic        clear;
    logic        req_read;
    logic        req_write;
    logic [31:0] mar_in;
    logic [31:0] mdr_in;
    logic [31:0] ram_data_out;
    logic [8:0]  ram_address;
    logic [31:0] ram_data_in;
    logic        ram_write_enable;
    logic [31:0] mem_data_out;
    logic        busy;
    logic        done;
    logic        addr_error;

    int checks = 0;
    int errors = 0;
    int we_cycles = 0;

    typedef struct {
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] shadow [0:511];
    logic [31:0] last_rd;

    // External RAM: address registered every edge, write on the strobed edge.
    logic [31:0] ram [0:511];
    logic [8:0]  ram_addr_lat;
    logic        ram_init;

    mem_access_controller #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(9),
        .MAR_WIDTH (32)
    ) dut (
        .clk             (clk),
        .clear           (clear),
        .req_read        (req_read),
        .req_write       (req_write),
        .mar_in          (mar_in),
        .mdr_in          (mdr_in),
        .ram_data_out    (ram_data_out),
        .ram_address     (ram_address),
        .ram_data_in     (ram_data_in),
        .ram_write_enable(ram_write_enable),
        .mem_data_out    (mem_data_out),
        .busy            (busy),
        .done            (done),
        .addr_error      (addr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 512; i++) ram[i] <= '0;
        end else if (ram_write_enable) begin
            ram[ram_address] <= ram_data_in;
        end
        ram_addr_lat <= ram_address;
    end
    assign ram_data_out = ram[ram_addr_lat];

    always @(negedge clk) begin : monitor
        exp_t e;
        if (ram_write_enable === 1'b1) we_cycles++;
        if (done === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_done: done pulsed with no pending request");
            end else begin
                e = sb.pop_front();
                if (mem_data_out !== e.data || addr_error !== e.err) begin
                    errors++;
                    $display("FAIL sb_result: mem_data_out=%h addr_error=%b, expected %h / %b",
                             mem_data_out, addr_error, e.data, e.err);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic rd, input logic [31:0] mar);
        exp_t e;
        e.err = (mar[31:9] != 0);
        if (!e.err && rd) last_rd = shadow[mar[8:0]];
        e.data = last_rd;
        sb.push_back(e);
    endtask

    // One complete request from IDLE; rd has priority when both are set.
    task automatic do_op(input logic rd, input logic wr, input logic [31:0] mar,
                         input logic [31:0] mdr, input string name);
        logic oor;
        int   lat;
        int   exp_lat;
        int   we0;
        oor     = (mar[31:9] != 0);
        exp_lat = oor ? 1 : (rd ? 3 : 2);
        push_exp(rd, mar);
        we0       = we_cycles;
        req_read  = rd;
        req_write = wr;
        mar_in    = mar;
        mdr_in    = mdr;
        tick();
        req_read  = 1'b0;
        req_write = 1'b0;
        mar_in    = $urandom;
        mdr_in    = $urandom;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL %s_busy_after_accept: busy=%b, expected 1", name, busy);
        end
        if (!oor && !rd) begin
            checks++;
            if (ram_write_enable !== 1'b1 || ram_address !== mar[8:0] || ram_data_in !== mdr) begin
                errors++;
                $display("FAIL %s_write_port: we=%b addr=%h data=%h, expected 1 / %h / %h",
                         name, ram_write_enable, ram_address, ram_data_in, mar[8:0], mdr);
            end
            shadow[mar[8:0]] = mdr;
        end
        lat = 1;
        while (done !== 1'b1 && lat < 10) begin
            tick();
            lat++;
        end
        checks++;
        if (lat != exp_lat) begin
            errors++;
            $display("FAIL %s_latency: done after %0d edges, expected %0d", name, lat, exp_lat);
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse_end: done=%b busy=%b, expected 0 / 0", name, done, busy);
        end
        checks++;
        if (we_cycles - we0 != ((wr && !rd && !oor) ? 1 : 0)) begin
            errors++;
            $display("FAIL %s_we_cycles: %0d strobe cycles, expected %0d",
                     name, we_cycles - we0, (wr && !rd && !oor) ? 1 : 0);
        end
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: done=%b, expected 1 within 10 cycles", name, done);
        end
    endtask

    task automatic test_reset();
        clear     = 1'b1;
        ram_init  = 1'b1;
        req_read  = 1'b0;
        req_write = 1'b0;
        mar_in    = '0;
        mdr_in    = '0;
        last_rd   = '0;
        for (int i = 0; i < 512; i++) shadow[i] = '0;
        #1;
        checks++;
        if ({ram_address, ram_data_in, ram_write_enable, mem_data_out, busy, done, addr_error} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%h wdata=%h we=%b rdata=%h busy=%b done=%b err=%b, expected all 0",
                     ram_address, ram_data_in, ram_write_enable, mem_data_out, busy, done, addr_error);
        end
        tick();
        tick();
        ram_init = 1'b0;
        #2;
        clear = 1'b0;
        tick();
    endtask

    task automatic test_write();
        do_op(1'b0, 1'b1, 32'h0000_0005, 32'hDEAD_BEEF, "write");
        do_op(1'b0, 1'b1, 32'h0000_01FF, 32'h1234_5678, "write_top");
    endtask

    task automatic test_read_back();
        do_op(1'b1, 1'b0, 32'h0000_0005, 32'h0, "read_back");
        do_op(1'b1, 1'b0, 32'h0000_0006, 32'h0, "read_zero");
    endtask

    task automatic test_out_of_range();
        do_op(1'b0, 1'b1, 32'h0000_0200, 32'h1111_1111, "oor_write");
        tick();
        checks++;
        if (addr_error !== 1'b1) begin
            errors++;
            $display("FAIL oor_hold: addr_error=%b, expected 1", addr_error);
        end
        do_op(1'b1, 1'b0, 32'h8000_0000, 32'h0, "oor_read");
        do_op(1'b1, 1'b0, 32'h0000_01FF, 32'h0, "read_1ff");
    endtask

    task automatic test_conflict();
        do_op(1'b1, 1'b1, 32'h0000_0005, 32'h0000_0BAD, "both_req");
        do_op(1'b1, 1'b0, 32'h0000_0005, 32'h0, "both_req_check");
    endtask

    task automatic test_ignore_busy();
        int we0;
        we0 = we_cycles;
        push_exp(1'b1, 32'h0000_01FF);
        req_read = 1'b1;
        mar_in   = 32'h0000_01FF;
        tick();
        req_read  = 1'b0;
        req_write = 1'b1;
        mar_in    = 32'h0000_0007;
        mdr_in    = 32'hFFFF_0000;
        tick();
        req_read = 1'b1;
        wait_done("busy_toggle");
        tick();
        req_read  = 1'b0;
        req_write = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (busy !== 1'b0) begin
                errors++;
                $display("FAIL busy_toggle_idle: busy=%b, expected 0", busy);
            end
        end
        checks++;
        if (we_cycles != we0) begin
            errors++;
            $display("FAIL busy_toggle_we: %0d strobe cycles, expected 0", we_cycles - we0);
        end
    endtask

    task automatic test_back_to_back();
        push_exp(1'b1, 32'h0000_0005);
        push_exp(1'b1, 32'h0000_0005);
        req_read = 1'b1;
        mar_in   = 32'h0000_0005;
        tick();
        wait_done("b2b_first");
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: busy=%b, expected 0", busy);
        end
        tick();
        req_read = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL b2b_reaccept: busy=%b, expected 1", busy);
        end
        wait_done("b2b_second");
        tick();
    endtask

    task automatic test_async_reset();
        do_op(1'b0, 1'b1, 32'h0001_0000, 32'h0, "pre_reset_err");
        @(posedge clk);
        #3;
        clear = 1'b1;
        #1;
        checks++;
        if ({ram_address, ram_data_in, ram_write_enable, mem_data_out, busy, done, addr_error} !== '0) begin
            errors++;
            $display("FAIL async_reset: addr=%h wdata=%h we=%b rdata=%h busy=%b done=%b err=%b, expected all 0",
                     ram_address, ram_data_in, ram_write_enable, mem_data_out, busy, done, addr_error);
        end
        last_rd = '0;
        #2;
        clear = 1'b0;
        tick();
    endtask

    task automatic test_abort();
        int we0;
        req_write = 1'b1;
        mar_in    = 32'h0000_0010;
        mdr_in    = 32'hCAFE_F00D;
        tick();
        req_write = 1'b0;
        checks++;
        if (ram_write_enable !== 1'b1) begin
            errors++;
            $display("FAIL abort_in_wr: we=%b, expected 1", ram_write_enable);
        end
        #2;
        clear = 1'b1;
        #1;
        checks++;
        if (ram_write_enable !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_drop: we=%b busy=%b done=%b, expected 0 / 0 / 0",
                     ram_write_enable, busy, done);
        end
        last_rd = '0;
        #2;
        clear = 1'b0;
        we0   = we_cycles;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL abort_quiet: done=%b busy=%b, expected 0 / 0", done, busy);
            end
        end
        checks++;
        if (we_cycles != we0) begin
            errors++;
            $display("FAIL abort_we: %0d strobe cycles, expected 0", we_cycles - we0);
        end
        do_op(1'b1, 1'b0, 32'h0000_0010, 32'h0, "abort_readback");
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_back();
        test_out_of_range();
        test_conflict();
        test_ignore_busy();
        test_back_to_back();
        test_async_reset();
        test_abort();
        tick();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d pending results, expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
